// File: rtl/ram_master_pkg.sv
// Shared constants and FSM encoding for the RAM bus initiator.
// Defaults here must track the attached single-port RAM geometry.
package ram_master_pkg;

    localparam int DEF_ADLINES   = 8;
    localparam int DEF_DATALINES = 32;
    localparam int DEF_LENW      = 4;
    localparam int DEF_RAMSIZE   = 1 << DEF_ADLINES;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_RD_SETUP = 2'd2,
        S_RD_DATA  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_master_addr_gen.sv
// Burst address generator: start-address load, wrapping increment,
// beat down-counter and last-beat flag.
module ram_master_addr_gen
    import ram_master_pkg::*;
#(
    parameter int ADLINES = DEF_ADLINES,
    parameter int LENW    = DEF_LENW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_inc,
    input  logic               i_dec,
    input  logic [ADLINES-1:0] i_addr,
    input  logic [LENW-1:0]    i_len,
    output logic [ADLINES-1:0] o_addr,
    output logic               o_last
);

    logic [ADLINES-1:0] r_addr;
    logic [LENW-1:0]    r_cnt;

    // Address wraps naturally at 2^ADLINES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_addr <= i_addr;
            r_cnt  <= i_len;
        end else begin
            if (i_inc) r_addr <= r_addr + 1'b1;
            if (i_dec) r_cnt  <= r_cnt - 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/ram_master.sv
// Burst initiator for a single-port synchronous RAM: sequences write
// beats, pipelines read beats and owns the master side of the data bus.
module ram_master
    import ram_master_pkg::*;
#(
    parameter int ADLINES   = DEF_ADLINES,
    parameter int DATALINES = DEF_DATALINES,
    parameter int LENW      = DEF_LENW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADLINES-1:0]   req_addr,
    input  logic [LENW-1:0]      req_len,
    input  logic [DATALINES-1:0] wr_data,
    output logic                 wr_data_ready,
    output logic                 resp_valid,
    output logic [DATALINES-1:0] resp_rdata,
    output logic [ADLINES-1:0]   ram_address,
    inout  wire  [DATALINES-1:0] ram_data,
    output logic                 ram_read,
    output logic                 ram_write
);

    state_t r_state;
    state_t w_nstate;

    logic r_req_ready;
    logic r_ram_read;
    logic r_ram_write;
    logic r_wr_rdy;
    logic r_resp_valid;
    logic [DATALINES-1:0] r_rdata;

    logic w_req_ready;
    logic w_ram_read;
    logic w_ram_write;
    logic w_wr_rdy;
    logic w_resp_valid;
    logic w_capture;
    logic w_load;
    logic w_inc;
    logic w_dec;
    logic w_last;

    ram_master_addr_gen #(
        .ADLINES (ADLINES),
        .LENW    (LENW)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_inc  (w_inc),
        .i_dec  (w_dec),
        .i_addr (req_addr),
        .i_len  (req_len),
        .o_addr (ram_address),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_ram_read   <= 1'b0;
            r_ram_write  <= 1'b0;
            r_wr_rdy     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_nstate;
            r_req_ready  <= w_req_ready;
            r_ram_read   <= w_ram_read;
            r_ram_write  <= w_ram_write;
            r_wr_rdy     <= w_wr_rdy;
            r_resp_valid <= w_resp_valid;
            if (w_capture) r_rdata <= ram_data;
        end
    end

    // Next-state logic produces the registered output values for the next cycle
    always_comb begin
        w_nstate     = r_state;
        w_req_ready  = 1'b0;
        w_ram_read   = 1'b0;
        w_ram_write  = 1'b0;
        w_wr_rdy     = 1'b0;
        w_resp_valid = 1'b0;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_load      = 1'b1;
                    w_req_ready = 1'b0;
                    if (req_we) begin
                        w_nstate    = S_WRITE;
                        w_ram_write = 1'b1;
                        w_wr_rdy    = 1'b1;
                    end else begin
                        w_nstate = S_RD_SETUP;
                    end
                end
            end
            S_WRITE: begin
                if (w_last) begin
                    w_nstate    = S_IDLE;
                    w_req_ready = 1'b1;
                end else begin
                    w_ram_write = 1'b1;
                    w_wr_rdy    = 1'b1;
                    w_inc       = 1'b1;
                    w_dec       = 1'b1;
                end
            end
            S_RD_SETUP: begin
                w_nstate   = S_RD_DATA;
                w_ram_read = 1'b1;
                w_inc      = 1'b1;
            end
            S_RD_DATA: begin
                w_capture    = 1'b1;
                w_resp_valid = 1'b1;
                w_inc        = 1'b1;
                if (w_last) begin
                    w_nstate    = S_IDLE;
                    w_req_ready = 1'b1;
                end else begin
                    w_ram_read = 1'b1;
                    w_dec      = 1'b1;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    assign req_ready     = r_req_ready;
    assign ram_read      = r_ram_read;
    assign ram_write     = r_ram_write;
    assign wr_data_ready = r_wr_rdy;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_rdata;

    // Only the WRITE state drives the bus; reset releases it immediately
    assign ram_data = (r_state == S_WRITE) ? wr_data : {DATALINES{1'bz}};

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a behavioural single-port RAM.
// Table-driven bursts plus hand sequences for turnaround and abort.
module tb_ram_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic [31:0] wr_data;
    logic        wr_data_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [7:0]  ram_address;
    wire  [31:0] ram_data;
    logic        ram_read;
    logic        ram_write;

    int n_checks = 0;
    int n_err    = 0;

    ram_master dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .wr_data       (wr_data),
        .wr_data_ready (wr_data_ready),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .ram_address   (ram_address),
        .ram_data      (ram_data),
        .ram_read      (ram_read),
        .ram_write     (ram_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered output, driven onto the bus while read is high
    logic [31:0] mem [0:255];
    logic [31:0] ram_out;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        ram_out = 32'h0;
    end

    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_data;
        ram_out <= mem[ram_address];
    end

    assign ram_data = ram_read ? ram_out : 32'hzzzzzzzz;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        n_checks++;
        if (ram_read && ram_write) begin
            n_err++;
            $display("FAIL bus_excl: ram_read and ram_write both 1 at %0t", $time);
        end
    end

    typedef struct packed {
        logic            we;
        logic [7:0]      addr;
        logic [3:0]      len;
        logic [3:0][31:0] d;
    } vec_t;

    task automatic wait_ready();
        int ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        chk("ready_timeout", 32'(ok), 32'd1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_ram_read", {31'b0, ram_read}, 32'd0);
        chk("rst_ram_write", {31'b0, ram_write}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_wr_rdy", {31'b0, wr_data_ready}, 32'd0);
        chk("rst_ram_addr", {24'b0, ram_address}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
    endtask

    task automatic run_write(input vec_t v);
        int n;
        logic [7:0] a;
        n = int'(v.len) + 1;
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = v.addr;
        req_len   = v.len;
        wr_data   = v.d[0];
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            wr_data = v.d[k];
            a = v.addr + 8'(k);
            @(negedge clk);
            chk("wr_en", {31'b0, ram_write}, 32'd1);
            chk("wr_rdy", {31'b0, wr_data_ready}, 32'd1);
            chk("wr_addr", {24'b0, ram_address}, {24'b0, a});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("wr_end_we", {31'b0, ram_write}, 32'd0);
        chk("wr_end_ready", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_read(input vec_t v);
        int n;
        int got;
        n = int'(v.len) + 1;
        got = 0;
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = v.addr;
        req_len   = v.len;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c < n + 6; c++) begin
            @(negedge clk);
            if (c == 1) chk("rd_setup_addr", {24'b0, ram_address}, {24'b0, v.addr});
            if (c == n + 1) chk("rd_busy", {31'b0, req_ready}, 32'd0);
            if (resp_valid) begin
                if (got == 0) chk("rd_first_lat", 32'(c), 32'd3);
                chk("rd_data", resp_rdata, v.d[got]);
                got++;
                if (got == n) begin
                    chk("rd_last_cycle", 32'(c), 32'(n + 2));
                    chk("rd_last_ready", {31'b0, req_ready}, 32'd1);
                    break;
                end
            end
        end
        chk("rd_count", 32'(got), 32'(n));
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{we: 1'b1, addr: 8'h10, len: 4'd0, d: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}};
        tbl[1] = '{we: 1'b0, addr: 8'h10, len: 4'd0, d: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}};
        tbl[2] = '{we: 1'b1, addr: 8'h20, len: 4'd3, d: {32'd4, 32'd3, 32'd2, 32'd1}};
        tbl[3] = '{we: 1'b0, addr: 8'h20, len: 4'd3, d: {32'd4, 32'd3, 32'd2, 32'd1}};
        tbl[4] = '{we: 1'b1, addr: 8'hFE, len: 4'd2, d: {32'h0, 32'hC, 32'hB, 32'hA}};
        tbl[5] = '{we: 1'b0, addr: 8'hFE, len: 4'd2, d: {32'h0, 32'hC, 32'hB, 32'hA}};
        tbl[6] = '{we: 1'b0, addr: 8'h00, len: 4'd0, d: {32'h0, 32'h0, 32'h0, 32'hC}};
        tbl[7] = '{we: 1'b0, addr: 8'h21, len: 4'd1, d: {32'h0, 32'h0, 32'd3, 32'd2}};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h0;
        req_len   = 4'h0;
        wr_data   = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst_n = 1'b1;
        #1;
        chk("rel_ready_low", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_ready_high", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].we) run_write(tbl[i]);
            else run_read(tbl[i]);
        end

        chk("mem_fe", mem[8'hFE], 32'hA);
        chk("mem_ff", mem[8'hFF], 32'hB);
        chk("mem_00", mem[8'h00], 32'hC);

        // Read then write with req_valid held; fields change after acceptance
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h20;
        req_len   = 4'd1;
        @(posedge clk);
        #1;
        req_we   = 1'b1;
        req_addr = 8'h30;
        req_len  = 4'd0;
        wr_data  = 32'h77;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("b2b_rd3", {31'b0, ram_read}, 32'd1);
                chk("b2b_d0", resp_rdata, 32'd1);
            end
            if (c == 4) begin
                chk("b2b_idle_rd", {31'b0, ram_read}, 32'd0);
                chk("b2b_idle_wr", {31'b0, ram_write}, 32'd0);
                chk("b2b_idle_rdy", {31'b0, req_ready}, 32'd1);
                chk("b2b_d1", resp_rdata, 32'd2);
            end
            if (c == 5) begin
                chk("b2b_wr", {31'b0, ram_write}, 32'd1);
                chk("b2b_waddr", {24'b0, ram_address}, 32'h30);
                chk("b2b_rv", {31'b0, resp_valid}, 32'd0);
            end
            if (c == 4) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_mem30", mem[8'h30], 32'h77);

        // Mid-simulation reset with non-zero resp_rdata
        run_read(tbl[1]);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst_n = 1'b1;
        #1;
        chk("rel2_ready_low", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel2_ready_high", {31'b0, req_ready}, 32'd1);

        // Abort an 8-beat write during beat 2
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h40;
        req_len   = 4'd7;
        wr_data   = 32'hA0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_data = 32'hA0 + 32'(k);
            @(posedge clk);
            #1;
        end
        wr_data = 32'hA2;
        chk("abort_pre_we", {31'b0, ram_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_we", {31'b0, ram_write}, 32'd0);
        chk("abort_wrdy", {31'b0, wr_data_ready}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_rv", {31'b0, resp_valid}, 32'd0);
        end
        chk("abort_m40", mem[8'h40], 32'hA0);
        chk("abort_m41", mem[8'h41], 32'hA1);
        chk("abort_m42", mem[8'h42], 32'h0);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_abort_rv", {31'b0, resp_valid}, 32'd0);
            chk("post_abort_we", {31'b0, ram_write}, 32'd0);
        end
        chk("post_abort_rdy", {31'b0, req_ready}, 32'd1);
        chk("post_abort_m42", mem[8'h42], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
